dma_in: RTL and testbench

- Inbound DMA engine: the stream-to-memory counterpart of the outbound DMA.
- Accepts a descriptor (start address, length, timer trigger, direction) and then absorbs `length` words from a crossbar stream.
- Buffers the words in an internal FWFT FIFO and writes them to consecutive memory addresses through a valid/ready write port.
- Signals completion with a one-cycle strobe and a sticky interrupt.

---
 rtl/dma_pkg.sv | 16 +
 rtl/fwft_sc_fifo.sv | 61 ++++++
 rtl/dma_in.sv | 189 ++++++++++++++++++
 tb/tb_dma_in.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA engines: state encoding, status layout and timer constant.
package dma_pkg;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_ENABLE = 2'd1,
        S_DRAIN  = 2'd2
    } dma_state_e;

    localparam int STATUS_STATE_LSB = 30;
    localparam int STATUS_IRQ_BIT   = 29;
    localparam int STATUS_CNT_W     = 29;

    localparam logic [31:0] TIMER_IMMEDIATE = 32'hFFFF_FFFF;

endpackage

// File: rtl/fwft_sc_fifo.sv
// Single-clock first-word-fall-through FIFO with an almost-full flag on free space.
module fwft_sc_fifo #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 32,
    parameter int ALMOST_FULL = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wrEn,
    input  logic [WIDTH-1:0] i_wrData,
    input  logic             i_rdEn,
    output logic [WIDTH-1:0] o_rdData,
    output logic             o_rdDataVld,
    output logic             o_afull
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_CNT = (AW+1)'(ALMOST_FULL);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full      = (r_count == FULL_CNT);
    assign w_push      = i_wrEn && !w_full;
    assign w_pop       = i_rdEn && o_rdDataVld;
    assign o_rdDataVld = (r_count != '0);
    assign o_rdData    = r_mem[r_rdPtr];
    assign o_afull     = ((FULL_CNT - r_count) <= AFULL_CNT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wrPtr] <= i_wrData;
    end

    // The producer's almost-full margin must make this unreachable.
    always_ff @(posedge i_clk) begin
        if (!i_rst) assert (!(i_wrEn && w_full));
    end

endmodule

// File: rtl/dma_in.sv
// Inbound DMA: absorbs a descriptor-sized stream into a FIFO and writes it to consecutive addresses.
// Optional early termination on t1_last is enabled by defining DMA_IN_LAST_TERM_EN.
module dma_in
    import dma_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int WIDTH       = 32,
    parameter int ALMOST_FULL = 4
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             config_valid,
    output logic             config_ready,
    input  logic [31:0]      config_payload_startAddr,
    input  logic [31:0]      config_payload_length,
    input  logic [31:0]      config_payload_timerInit,
    input  logic             config_payload_reverse,
    input  logic [31:0]      ctimer,
    input  logic             dmaReset,
    output logic [31:0]      status,
    output logic             strobe_complete,
    output logic             interrupt,
    input  logic             interrupt_clear,
    input  logic [WIDTH-1:0] t1_data,
    input  logic             t1_last,
    input  logic             t1_valid,
    output logic             t1_ready,
    output logic [31:0]      o0_addr,
    output logic [WIDTH-1:0] o0_data,
    output logic             o0_valid,
    input  logic             o0_ready
);

    dma_state_e  r_state;
    dma_state_e  w_stateNext;
    logic [31:0] r_addr;
    logic [31:0] r_len;
    logic [31:0] r_accCnt;
    logic [31:0] r_wrCnt;
    logic        r_reverse;
    logic        r_afull;
    logic        r_interrupt;
    logic        r_strobe;

    logic [31:0]      w_accNext;
    logic [31:0]      w_wrNext;
    logic             w_timerHit;
    logic             w_start;
    logic             w_push;
    logic             w_pop;
    logic             w_done;
    logic             w_termShort;
    logic             w_fifoRst;
    logic             w_fifoVld;
    logic             w_fifoAfull;
    logic [WIDTH-1:0] w_fifoData;
    logic             w_unusedBits;

    assign w_fifoRst = !srst_n || dmaReset;

    fwft_sc_fifo #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .ALMOST_FULL (ALMOST_FULL)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst       (w_fifoRst),
        .i_wrEn      (w_push),
        .i_wrData    (t1_data),
        .i_rdEn      (w_pop),
        .o_rdData    (w_fifoData),
        .o_rdDataVld (w_fifoVld),
        .o_afull     (w_fifoAfull)
    );

    always_comb begin
        w_stateNext  = r_state;
        config_ready = 1'b0;
        t1_ready     = 1'b0;
        w_start      = 1'b0;
        w_done       = 1'b0;
        w_termShort  = 1'b0;
        w_accNext    = r_accCnt + 32'd1;
        w_wrNext     = r_wrCnt + 32'd1;
        w_timerHit   = (ctimer == config_payload_timerInit) ||
                       (config_payload_timerInit == TIMER_IMMEDIATE);
        o0_valid     = w_fifoVld && (r_state != S_WAIT) && !dmaReset;
        w_pop        = o0_valid && o0_ready;

        case (r_state)
            S_WAIT: begin
                if (!dmaReset && config_valid) begin
                    if (config_payload_length == '0) begin
                        config_ready = 1'b1;
                    end else if (w_timerHit) begin
                        w_start     = 1'b1;
                        w_stateNext = S_ENABLE;
                    end
                end
            end
            S_ENABLE: begin
                if (dmaReset) begin
                    config_ready = 1'b1;
                    w_stateNext  = S_WAIT;
                end else begin
                    t1_ready = !r_afull && (r_accCnt < r_len);
                    if (t1_valid && t1_ready) begin
                        if (w_accNext == r_len) begin
                            w_stateNext = S_DRAIN;
`ifdef DMA_IN_LAST_TERM_EN
                        end else if (t1_last) begin
                            w_termShort = 1'b1;
                            w_stateNext = S_DRAIN;
`endif
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (dmaReset) begin
                    config_ready = 1'b1;
                    w_stateNext  = S_WAIT;
                end else if (w_pop && (w_wrNext == r_len)) begin
                    config_ready = 1'b1;
                    w_done       = 1'b1;
                    w_stateNext  = S_WAIT;
                end
            end
            default: w_stateNext = S_WAIT;
        endcase
    end

    assign w_push = t1_valid && t1_ready;

    // Almost-full is sampled on pushes so the flag lags by one beat; the threshold absorbs that beat.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_state     <= S_WAIT;
            r_addr      <= '0;
            r_len       <= '0;
            r_accCnt    <= '0;
            r_wrCnt     <= '0;
            r_reverse   <= 1'b0;
            r_afull     <= 1'b0;
            r_interrupt <= 1'b0;
            r_strobe    <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_strobe <= w_done;
            if (w_done) begin
                r_interrupt <= 1'b1;
            end else if (interrupt_clear) begin
                r_interrupt <= 1'b0;
            end
            if (w_start) begin
                r_addr    <= config_payload_startAddr;
                r_len     <= config_payload_length;
                r_reverse <= config_payload_reverse;
                r_accCnt  <= '0;
                r_wrCnt   <= '0;
            end else begin
                if (w_push)      r_accCnt <= w_accNext;
                if (w_termShort) r_len    <= w_accNext;
                if (w_pop) begin
                    r_wrCnt <= w_wrNext;
                    r_addr  <= r_reverse ? (r_addr - 32'd1) : (r_addr + 32'd1);
                end
            end
            if (dmaReset) begin
                r_afull <= 1'b0;
            end else if (w_push || !w_fifoAfull) begin
                r_afull <= w_fifoAfull;
            end
        end
    end

`ifdef DMA_IN_LAST_TERM_EN
    assign w_unusedBits = ^r_wrCnt[31:STATUS_CNT_W];
`else
    assign w_unusedBits = ^{r_wrCnt[31:STATUS_CNT_W], t1_last};
`endif

    assign status          = {r_state, r_interrupt, r_wrCnt[STATUS_CNT_W-1:0]};
    assign strobe_complete = r_strobe;
    assign interrupt       = r_interrupt;
    assign o0_addr         = r_addr;
    assign o0_data         = w_fifoData;

endmodule

// File: tb/tb_dma_in.sv
// Directed self-checking bench for dma_in; exercises DMA_IN_LAST_TERM_EN when that macro is defined.
module tb_dma_in;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int AFULL = 4;
    localparam logic [31:0] TIMER_IMM = 32'hFFFF_FFFF;

    logic             clk = 1'b0;
    logic             srst_n;
    logic             config_valid;
    logic             config_ready;
    logic [31:0]      config_payload_startAddr;
    logic [31:0]      config_payload_length;
    logic [31:0]      config_payload_timerInit;
    logic             config_payload_reverse;
    logic [31:0]      ctimer;
    logic             dmaReset;
    logic [31:0]      status;
    logic             strobe_complete;
    logic             interrupt;
    logic             interrupt_clear;
    logic [WIDTH-1:0] t1_data;
    logic             t1_last;
    logic             t1_valid;
    logic             t1_ready;
    logic [31:0]      o0_addr;
    logic [WIDTH-1:0] o0_data;
    logic             o0_valid;
    logic             o0_ready;

    int checks = 0;
    int errors = 0;

    int nCfg = 0;
    int nStrobe = 0;
    int nAcc = 0;
    int cycle = 0;
    int cfgCycle = 0;
    int strobeCycle = 0;
    logic [31:0] qAddr[$];
    logic [31:0] qData[$];

    always #5 clk = ~clk;

    dma_in #(
        .DEPTH       (DEPTH),
        .WIDTH       (WIDTH),
        .ALMOST_FULL (AFULL)
    ) dut (
        .clk                      (clk),
        .srst_n                   (srst_n),
        .config_valid             (config_valid),
        .config_ready             (config_ready),
        .config_payload_startAddr (config_payload_startAddr),
        .config_payload_length    (config_payload_length),
        .config_payload_timerInit (config_payload_timerInit),
        .config_payload_reverse   (config_payload_reverse),
        .ctimer                   (ctimer),
        .dmaReset                 (dmaReset),
        .status                   (status),
        .strobe_complete          (strobe_complete),
        .interrupt                (interrupt),
        .interrupt_clear          (interrupt_clear),
        .t1_data                  (t1_data),
        .t1_last                  (t1_last),
        .t1_valid                 (t1_valid),
        .t1_ready                 (t1_ready),
        .o0_addr                  (o0_addr),
        .o0_data                  (o0_data),
        .o0_valid                 (o0_valid),
        .o0_ready                 (o0_ready)
    );

    // Record handshakes and pulses mid-cycle, away from the edge where inputs change.
    always @(negedge clk) begin
        cycle = cycle + 1;
        if (srst_n) begin
            if (o0_valid && o0_ready) begin
                qAddr.push_back(o0_addr);
                qData.push_back(o0_data);
            end
            if (config_ready) begin
                nCfg = nCfg + 1;
                cfgCycle = cycle;
            end
            if (strobe_complete) begin
                nStrobe = nStrobe + 1;
                strobeCycle = cycle;
            end
            if (t1_valid && t1_ready) nAcc = nAcc + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ctimer = ctimer + 32'd1;
    endtask

    task automatic startDesc(input logic [31:0] addr, input logic [31:0] len,
                             input logic [31:0] tinit, input logic rev);
        config_payload_startAddr = addr;
        config_payload_length    = len;
        config_payload_timerInit = tinit;
        config_payload_reverse   = rev;
        config_valid             = 1'b1;
    endtask

    task automatic sendStream(input logic [WIDTH-1:0] base, input int n, input int lastIdx,
                              input int releaseAt, output int timeouts,
                              output int accAtRel, output logic rdyAtRel);
        int cyc = 0;
        timeouts = 0;
        accAtRel = 0;
        rdyAtRel = 1'b0;
        for (int i = 0; i < n; i++) begin
            bit accepted = 1'b0;
            int waited = 0;
            t1_valid = 1'b1;
            t1_data  = base + WIDTH'(i);
            t1_last  = (i == lastIdx);
            while (!accepted && waited < 300) begin
                @(negedge clk);
                accepted = t1_ready;
                tick();
                cyc++;
                waited++;
                if (cyc == releaseAt) begin
                    accAtRel = nAcc;
                    rdyAtRel = t1_ready;
                    o0_ready = 1'b1;
                end
            end
            if (!accepted) timeouts++;
        end
        t1_valid = 1'b0;
        t1_last  = 1'b0;
    endtask

    task automatic waitDone(input int budget, output bit ok);
        int base = nCfg;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (nCfg != base) begin
                ok = 1'b1;
                break;
            end
        end
        config_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        srst_n = 1'b0;
        config_valid = 1'b0;
        config_payload_startAddr = '0;
        config_payload_length = '0;
        config_payload_timerInit = '0;
        config_payload_reverse = 1'b0;
        ctimer = '0;
        dmaReset = 1'b0;
        interrupt_clear = 1'b0;
        t1_data = '0;
        t1_last = 1'b0;
        t1_valid = 1'b0;
        o0_ready = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({config_ready, strobe_complete, interrupt, t1_ready, o0_valid} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000",
                     {config_ready, strobe_complete, interrupt, t1_ready, o0_valid});
        end
        checks++;
        if (status !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h expected 00000000", status);
        end
        srst_n = 1'b1;
        tick();
        checks++;
        if (status !== 32'h0 || t1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: status %h t1_ready %b expected 00000000 0", status, t1_ready);
        end
    endtask

    task automatic test_basic();
        int wb = qAddr.size();
        int cb = nCfg;
        int sb = nStrobe;
        int tmo, accR;
        logic rdyR;
        bit ok;
        logic [31:0] got;
        o0_ready = 1'b1;
        startDesc(32'h100, 32'd4, TIMER_IMM, 1'b0);
        sendStream(32'hA0, 4, -1, 0, tmo, accR, rdyR);
        waitDone(200, ok);
        checks++;
        if (tmo !== 0 || !ok) begin
            errors++;
            $display("[TB] FAIL basic_progress: timeouts %0d done %0d expected 0 1", tmo, ok);
        end
        checks++;
        if (qAddr.size() - wb !== 4) begin
            errors++;
            $display("[TB] FAIL basic_write_count: got %0d expected 4", qAddr.size() - wb);
        end
        for (int i = 0; i < 4; i++) begin
            got = (wb + i < qAddr.size()) ? qAddr[wb + i] : 32'hDEAD_BEEF;
            checks++;
            if (got !== 32'h100 + 32'(i)) begin
                errors++;
                $display("[TB] FAIL basic_addr[%0d]: got %h expected %h", i, got, 32'h100 + 32'(i));
            end
            got = (wb + i < qData.size()) ? qData[wb + i] : 32'hDEAD_BEEF;
            checks++;
            if (got !== 32'hA0 + 32'(i)) begin
                errors++;
                $display("[TB] FAIL basic_data[%0d]: got %h expected %h", i, got, 32'hA0 + 32'(i));
            end
        end
        checks++;
        if (nCfg - cb !== 1 || nStrobe - sb !== 1) begin
            errors++;
            $display("[TB] FAIL basic_pulses: config_ready %0d strobe %0d expected 1 1", nCfg - cb, nStrobe - sb);
        end
        checks++;
        if (strobeCycle !== cfgCycle + 1) begin
            errors++;
            $display("[TB] FAIL basic_strobe_timing: strobe cycle %0d expected %0d", strobeCycle, cfgCycle + 1);
        end
        checks++;
        if (interrupt !== 1'b1 || status !== {2'b00, 1'b1, 29'd4}) begin
            errors++;
            $display("[TB] FAIL basic_status: interrupt %b status %h expected 1 %h",
                     interrupt, status, {2'b00, 1'b1, 29'd4});
        end
    endtask

    task automatic test_interrupt_clear();
        tick(); tick();
        checks++;
        if (interrupt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_sticky: got %b expected 1", interrupt);
        end
        interrupt_clear = 1'b1;
        tick();
        interrupt_clear = 1'b0;
        checks++;
        if (interrupt !== 1'b0 || status[29] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_clear: interrupt %b status[29] %b expected 0 0", interrupt, status[29]);
        end
    endtask

    task automatic test_zero_length();
        startDesc(32'h700, 32'd0, TIMER_IMM, 1'b0);
        @(negedge clk);
        checks++;
        if (config_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_len_ready: got %b expected 1", config_ready);
        end
        tick();
        config_valid = 1'b0;
        checks++;
        if (status[31:30] !== 2'd0 || t1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_len_state: state %0d t1_ready %b expected 0 0", status[31:30], t1_ready);
        end
    endtask

    task automatic test_reverse_wrap();
        int wb = qAddr.size();
        int tmo, accR;
        logic rdyR;
        bit ok;
        logic [31:0] got;
        logic [31:0] expAddr [3];
        expAddr[0] = 32'h0000_0001;
        expAddr[1] = 32'h0000_0000;
        expAddr[2] = 32'hFFFF_FFFF;
        o0_ready = 1'b1;
        startDesc(32'h1, 32'd3, TIMER_IMM, 1'b1);
        sendStream(32'hB0, 3, -1, 0, tmo, accR, rdyR);
        waitDone(200, ok);
        checks++;
        if (tmo !== 0 || !ok || qAddr.size() - wb !== 3) begin
            errors++;
            $display("[TB] FAIL reverse_progress: timeouts %0d done %0d writes %0d expected 0 1 3",
                     tmo, ok, qAddr.size() - wb);
        end
        for (int i = 0; i < 3; i++) begin
            got = (wb + i < qAddr.size()) ? qAddr[wb + i] : 32'hDEAD_BEEF;
            checks++;
            if (got !== expAddr[i]) begin
                errors++;
                $display("[TB] FAIL reverse_addr[%0d]: got %h expected %h", i, got, expAddr[i]);
            end
        end
    endtask

    task automatic test_timer();
        int wb = qAddr.size();
        int early = 0;
        int tmo, accR;
        logic rdyR;
        bit ok;
        o0_ready = 1'b1;
        ctimer = 32'd0;
        startDesc(32'h600, 32'd2, 32'd50, 1'b0);
        while (ctimer <= 32'd50) begin
            if (t1_ready) early++;
            tick();
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("[TB] FAIL timer_early_ready: got %0d cycles expected 0", early);
        end
        checks++;
        if (t1_ready !== 1'b1 || status[31:30] !== 2'd1) begin
            errors++;
            $display("[TB] FAIL timer_start: t1_ready %b state %0d expected 1 1", t1_ready, status[31:30]);
        end
        sendStream(32'h60, 2, -1, 0, tmo, accR, rdyR);
        waitDone(200, ok);
        checks++;
        if (tmo !== 0 || !ok || qAddr.size() - wb !== 2) begin
            errors++;
            $display("[TB] FAIL timer_complete: timeouts %0d done %0d writes %0d expected 0 1 2",
                     tmo, ok, qAddr.size() - wb);
        end
    endtask

    task automatic test_backpressure();
        int wb = qAddr.size();
        int ab = nAcc;
        int tmo, accR;
        logic rdyR;
        bit ok;
        logic [31:0] got;
        int badOrder = 0;
        o0_ready = 1'b0;
        startDesc(32'h200, 32'd16, TIMER_IMM, 1'b0);
        sendStream(32'hC00, 16, -1, 20, tmo, accR, rdyR);
        waitDone(300, ok);
        checks++;
        if (accR - ab !== 5 || rdyR !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_stall: accepted %0d t1_ready %b expected 5 0", accR - ab, rdyR);
        end
        checks++;
        if (tmo !== 0 || !ok || qAddr.size() - wb !== 16) begin
            errors++;
            $display("[TB] FAIL bp_complete: timeouts %0d done %0d writes %0d expected 0 1 16",
                     tmo, ok, qAddr.size() - wb);
        end
        for (int i = 0; i < 16; i++) begin
            got = (wb + i < qData.size()) ? qData[wb + i] : 32'hDEAD_BEEF;
            if (got !== 32'hC00 + 32'(i)) badOrder++;
            got = (wb + i < qAddr.size()) ? qAddr[wb + i] : 32'hDEAD_BEEF;
            if (got !== 32'h200 + 32'(i)) badOrder++;
        end
        checks++;
        if (badOrder !== 0) begin
            errors++;
            $display("[TB] FAIL bp_order: got %0d wrong fields expected 0", badOrder);
        end
    endtask

    task automatic test_dma_reset();
        int wb, cb, sb;
        int tmo, accR;
        logic rdyR;
        bit ok;
        interrupt_clear = 1'b1;
        tick();
        interrupt_clear = 1'b0;
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_pre_irq: got %b expected 0", interrupt);
        end
        wb = qAddr.size();
        cb = nCfg;
        sb = nStrobe;
        o0_ready = 1'b0;
        startDesc(32'h400, 32'd10, TIMER_IMM, 1'b0);
        sendStream(32'hE0, 3, -1, 0, tmo, accR, rdyR);
        dmaReset = 1'b1;
        @(negedge clk);
        checks++;
        if (config_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_ready_pulse: got %b expected 1", config_ready);
        end
        tick();
        dmaReset = 1'b0;
        config_valid = 1'b0;
        o0_ready = 1'b1;
        #1;
        checks++;
        if (status[31:30] !== 2'd0 || o0_valid !== 1'b0 || t1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_idle: state %0d o0_valid %b t1_ready %b expected 0 0 0",
                     status[31:30], o0_valid, t1_ready);
        end
        repeat (5) tick();
        checks++;
        if (tmo !== 0 || qAddr.size() - wb !== 0 || nStrobe - sb !== 0 || interrupt !== 1'b0 || nCfg - cb !== 1) begin
            errors++;
            $display("[TB] FAIL abort_effects: timeouts %0d writes %0d strobes %0d irq %b ready %0d expected 0 0 0 0 1",
                     tmo, qAddr.size() - wb, nStrobe - sb, interrupt, nCfg - cb);
        end
        wb = qAddr.size();
        sb = nStrobe;
        startDesc(32'h500, 32'd2, TIMER_IMM, 1'b0);
        sendStream(32'hF0, 2, -1, 0, tmo, accR, rdyR);
        waitDone(200, ok);
        checks++;
        if (!ok || qAddr.size() - wb !== 2 || nStrobe - sb !== 1 || interrupt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_next_desc: done %0d writes %0d strobes %0d irq %b expected 1 2 1 1",
                     ok, qAddr.size() - wb, nStrobe - sb, interrupt);
        end
        checks++;
        if (qData.size() >= wb + 2 && (qAddr[wb] !== 32'h500 || qData[wb + 1] !== 32'hF1)) begin
            errors++;
            $display("[TB] FAIL abort_next_data: addr0 %h data1 %h expected 00000500 000000f1",
                     qAddr[wb], qData[wb + 1]);
        end else if (qData.size() < wb + 2) begin
            errors++;
            $display("[TB] FAIL abort_next_data: got %0d writes expected 2", qData.size() - wb);
        end
    endtask

    task automatic test_last_term();
        int wb = qAddr.size();
        int sb = nStrobe;
        int tmo, accR;
        logic rdyR;
        bit ok;
        o0_ready = 1'b1;
        startDesc(32'h300, 32'd8, TIMER_IMM, 1'b0);
        sendStream(32'hD0, 5, 4, 0, tmo, accR, rdyR);
`ifdef DMA_IN_LAST_TERM_EN
        waitDone(200, ok);
        checks++;
        if (tmo !== 0 || !ok || qAddr.size() - wb !== 5 || nStrobe - sb !== 1) begin
            errors++;
            $display("[TB] FAIL last_short: timeouts %0d done %0d writes %0d strobes %0d expected 0 1 5 1",
                     tmo, ok, qAddr.size() - wb, nStrobe - sb);
        end
        checks++;
        if (status[28:0] !== 29'd5) begin
            errors++;
            $display("[TB] FAIL last_status_count: got %0d expected 5", status[28:0]);
        end
`else
        repeat (15) tick();
        checks++;
        if (status[31:30] !== 2'd1 || nStrobe - sb !== 0 || qAddr.size() - wb !== 5) begin
            errors++;
            $display("[TB] FAIL last_ignored: state %0d strobes %0d writes %0d expected 1 0 5",
                     status[31:30], nStrobe - sb, qAddr.size() - wb);
        end
        sendStream(32'hD5, 3, -1, 0, tmo, accR, rdyR);
        waitDone(200, ok);
        checks++;
        if (tmo !== 0 || !ok || qAddr.size() - wb !== 8 || nStrobe - sb !== 1) begin
            errors++;
            $display("[TB] FAIL last_full_length: timeouts %0d done %0d writes %0d strobes %0d expected 0 1 8 1",
                     tmo, ok, qAddr.size() - wb, nStrobe - sb);
        end
        checks++;
        if (status[28:0] !== 29'd8) begin
            errors++;
            $display("[TB] FAIL last_status_count: got %0d expected 8", status[28:0]);
        end
`endif
    endtask

    initial begin
        $display("[TB] starting dma_in bench");
        test_reset();
        test_basic();
        test_interrupt_clear();
        test_zero_length();
        test_reverse_wrap();
        test_timer();
        test_backpressure();
        test_dma_reset();
        test_last_term();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
